// File: rtl/sqrt_mult_param_pkg.sv
// Shared encodings for the sqrt/multiply unit: operation modes, FSM states
// and a small helper for sizing down-counters.
package sqrt_mult_param_pkg;

  typedef enum logic [1:0] {
    MODE_AMULSQB   = 2'b00,
    MODE_SQB       = 2'b01,
    MODE_AMULB     = 2'b10,
    MODE_SQAMULSQB = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQ1  = 3'd1,
    ST_SQ2  = 3'd2,
    ST_MUL  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Bits needed for a counter that must hold the value n
  function automatic int ctrWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sqrt_mult_param_isqrt_iter.sv
// Iterative integer square root, restoring bit-pair method. The start edge
// loads the operand and performs the first iteration, so the H-bit root is
// complete after exactly H edges and done_o pulses in the following cycle.
module isqrt_iter
  import sqrt_mult_param_pkg::*;
#(
  parameter int W = 8
)
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [W-1:0]     x_bi,
  output logic [W/2-1:0]   y_bo,
  output logic             busy_o,
  output logic             done_o
);

  localparam int H  = W / 2;
  localparam int RW = H + 3;
  localparam int CW = ctrWidth(H);

  logic [RW-1:0] r_rem;
  logic [H-1:0]  r_root;
  logic [W-1:0]  r_x;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic          w_load;
  logic [RW-1:0] w_remIn;
  logic [RW-1:0] w_remSh;
  logic [RW-1:0] w_trial;
  logic [RW-1:0] w_remNext;
  logic [H-1:0]  w_rootIn;
  logic [H-1:0]  w_rootNext;
  logic [W-1:0]  w_xIn;
  logic [W-1:0]  w_xNext;

  // One bit-pair step; on a load the step starts from a cleared remainder/root
  always_comb begin
    w_load   = start_i && !r_busy;
    w_remIn  = w_load ? '0   : r_rem;
    w_rootIn = w_load ? '0   : r_root;
    w_xIn    = w_load ? x_bi : r_x;
    w_remSh  = (w_remIn << 2) | {{(RW-2){1'b0}}, w_xIn[W-1:W-2]};
    w_trial  = {1'b0, w_rootIn, 2'b01};
    w_xNext  = w_xIn << 2;
    if (w_remSh >= w_trial) begin
      w_remNext  = w_remSh - w_trial;
      w_rootNext = (w_rootIn << 1) | {{(H-1){1'b0}}, 1'b1};
    end else begin
      w_remNext  = w_remSh;
      w_rootNext = w_rootIn << 1;
    end
  end

  // Iteration sequencing: first step on start, H-1 further steps while busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rem  <= '0;
      r_root <= '0;
      r_x    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_rem  <= w_remNext;
        r_root <= w_rootNext;
        r_x    <= w_xNext;
        r_cnt  <= CW'(H - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_remNext;
        r_root <= w_rootNext;
        r_x    <= w_xNext;
        r_cnt  <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign y_bo   = r_root;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: rtl/sqrt_mult_param.sv
// Mode-selectable product / integer square root unit. One shared sqrt engine
// (run twice for isqrt(A)*isqrt(B)) feeds an inline shift-add multiplier,
// all sequenced by a single FSM with registered busy/done/result outputs.
module sqrt_mult_param
  import sqrt_mult_param_pkg::*;
#(
  parameter int W = 8
)
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [1:0]     mode_i,
  input  logic [W-1:0]   a_bi,
  input  logic [W-1:0]   b_bi,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] y_bo
);

  localparam int H   = W / 2;
  localparam int MCW = ctrWidth(W);

  state_e         r_state;
  mode_e          r_mode;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [H-1:0]   r_sqA;
  logic           r_first;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [MCW-1:0] r_mulCnt;
  logic           r_busy;
  logic           r_done;
  logic [2*W-1:0] r_y;

  logic           w_sqStart;
  logic [W-1:0]   w_sqX;
  logic [H-1:0]   w_root;
  logic           w_engBusy;
  logic           w_engDone;
  logic [2*W-1:0] w_accNext;

  // Engine kick-off: first SQ1 cycle, or restart for isqrt(B) once isqrt(A) lands
  always_comb begin
    w_sqStart = (r_state == ST_SQ1) && !w_engBusy &&
                (r_first || (w_engDone && (r_mode == MODE_SQAMULSQB)));
    w_sqX     = (r_first && (r_mode == MODE_SQAMULSQB)) ? r_a : r_b;
    w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
  end

  isqrt_iter #(
    .W (W)
  ) u_isqrt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (w_sqStart),
    .x_bi    (w_sqX),
    .y_bo    (w_root),
    .busy_o  (w_engBusy),
    .done_o  (w_engDone)
  );

  // Top FSM plus operand latches and shift-add multiplier datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_AMULSQB;
      r_a      <= '0;
      r_b      <= '0;
      r_sqA    <= '0;
      r_first  <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mulCnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_y      <= '0;
    end else begin
      r_done  <= 1'b0;
      r_first <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_a     <= a_bi;
            r_b     <= b_bi;
            r_mode  <= mode_e'(mode_i);
            r_first <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= (mode_i == MODE_AMULB) ? ST_MUL : ST_SQ1;
          end
        end

        ST_SQ1: begin
          if (w_engDone) begin
            case (r_mode)
              MODE_SQB: begin
                r_y     <= {{(2*W-H){1'b0}}, w_root};
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end
              MODE_SQAMULSQB: begin
                r_sqA   <= w_root;
                r_state <= ST_SQ2;
              end
              default: begin
                r_mcand  <= {{W{1'b0}}, r_a};
                r_mplier <= {{(W-H){1'b0}}, w_root};
                r_acc    <= '0;
                r_mulCnt <= MCW'(H);
                r_state  <= ST_MUL;
              end
            endcase
          end
        end

        ST_SQ2: begin
          if (w_engDone) begin
            r_mcand  <= {{(2*W-H){1'b0}}, r_sqA};
            r_mplier <= {{(W-H){1'b0}}, w_root};
            r_acc    <= '0;
            r_mulCnt <= MCW'(H);
            r_state  <= ST_MUL;
          end
        end

        ST_MUL: begin
          if (r_first) begin
            r_mcand  <= {{W{1'b0}}, r_a};
            r_mplier <= r_b;
            r_acc    <= '0;
            r_mulCnt <= MCW'(W);
          end else begin
            r_acc    <= w_accNext;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_mulCnt <= r_mulCnt - MCW'(1);
            if (r_mulCnt == MCW'(1)) begin
              r_y     <= w_accNext;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign y_bo   = r_y;

endmodule

// File: tb/tb_sqrt_mult_param.sv
// Directed bench for sqrt_mult_param at W=8 and W=16, with a short random
// sweep checked against a simple floor-sqrt reference.
module tb_sqrt_mult_param;

  logic        clk;
  logic        rst;
  logic        start8;
  logic [1:0]  mode8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] y8;
  logic        start16;
  logic [1:0]  mode16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        busy16;
  logic        done16;
  logic [31:0] y16;

  int nAsserts = 0;
  int nFails   = 0;

  sqrt_mult_param #(.W(8)) dut8 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start8),
    .mode_i  (mode8),
    .a_bi    (a8),
    .b_bi    (b8),
    .busy_o  (busy8),
    .done_o  (done8),
    .y_bo    (y8)
  );

  sqrt_mult_param #(.W(16)) dut16 (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start16),
    .mode_i  (mode16),
    .a_bi    (a16),
    .b_bi    (b16),
    .busy_o  (busy16),
    .done_o  (done16),
    .y_bo    (y16)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nAsserts++;
    assert (obs === expv) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic curBusy(input int dut);
    return (dut == 8) ? busy8 : busy16;
  endfunction

  function automatic logic curDone(input int dut);
    return (dut == 8) ? done8 : done16;
  endfunction

  function automatic logic [63:0] curY(input int dut);
    return (dut == 8) ? {48'b0, y8} : {32'b0, y16};
  endfunction

  task automatic applyStimulus(input int dut, input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b);
    if (dut == 8) begin
      start8 = 1'b1; mode8 = mode; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start16 = 1'b1; mode16 = mode; a16 = a; b16 = b;
    end
  endtask

  task automatic dropStart(input int dut);
    if (dut == 8) start8 = 1'b0;
    else          start16 = 1'b0;
  endtask

  // Counts edges until done_o is seen (bounded), noting any busy_o dropout
  task automatic waitDone(input int dut, output int lat, output bit busyAll);
    lat = 0;
    busyAll = 1'b1;
    while (lat < 200) begin
      tick();
      lat++;
      if (!curBusy(dut)) busyAll = 1'b0;
      if (curDone(dut)) break;
    end
  endtask

  task automatic runOp(input int dut, input logic [1:0] mode, input logic [15:0] a, input logic [15:0] b,
                       output logic [63:0] y, output int lat, output bit busyAll);
    applyStimulus(dut, mode, a, b);
    tick();
    dropStart(dut);
    waitDone(dut, lat, busyAll);
    y = curY(dut);
  endtask

  function automatic longint isqrtRef(input longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint refResult(input logic [1:0] mode, input longint a, input longint b);
    case (mode)
      2'b00:   return a * isqrtRef(b);
      2'b01:   return isqrtRef(b);
      2'b10:   return a * b;
      default: return isqrtRef(a) * isqrtRef(b);
    endcase
  endfunction

  function automatic int refLatency(input logic [1:0] mode, input int w);
    case (mode)
      2'b00:   return w + 1;
      2'b01:   return w / 2 + 1;
      2'b10:   return w + 1;
      default: return 3 * (w / 2) + 1;
    endcase
  endfunction

  // Linear directed sequence followed by a short random sweep
  initial begin
    logic [63:0] y;
    int          lat;
    bit          busyAll;
    int          pulses;

    rst = 1'b1;
    start8 = 1'b0; mode8 = 2'b00; a8 = '0; b8 = '0;
    start16 = 1'b0; mode16 = 2'b00; a16 = '0; b16 = '0;
    tick();
    tick();
    checkOutput("reset_busy8", {63'b0, busy8}, 64'd0);
    checkOutput("reset_done8", {63'b0, done8}, 64'd0);
    checkOutput("reset_y8", curY(8), 64'd0);
    checkOutput("reset_busy16", {63'b0, busy16}, 64'd0);
    checkOutput("reset_done16", {63'b0, done16}, 64'd0);
    checkOutput("reset_y16", curY(16), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] mode 00, A=200 B=225");
    runOp(8, 2'b00, 16'd200, 16'd225, y, lat, busyAll);
    checkOutput("m00_y", y, 64'd3000);
    checkOutput("m00_lat", 64'(lat), 64'd9);
    checkOutput("m00_busy", {63'b0, busyAll}, 64'd1);
    tick();
    checkOutput("m00_done_pulse", {63'b0, done8}, 64'd0);
    checkOutput("m00_idle_busy", {63'b0, busy8}, 64'd0);
    checkOutput("m00_y_held", curY(8), 64'd3000);

    $display("[TB] mode 01 then back-to-back mode 10");
    runOp(8, 2'b01, 16'd0, 16'd255, y, lat, busyAll);
    checkOutput("m01_y", y, 64'd15);
    checkOutput("m01_lat", 64'(lat), 64'd5);
    tick();
    runOp(8, 2'b10, 16'd255, 16'd255, y, lat, busyAll);
    checkOutput("m10_y", y, 64'd65025);
    checkOutput("m10_lat", 64'(lat), 64'd9);
    checkOutput("m10_busy", {63'b0, busyAll}, 64'd1);

    $display("[TB] mode 11 and zero operand");
    tick();
    runOp(8, 2'b11, 16'd100, 16'd81, y, lat, busyAll);
    checkOutput("m11_y", y, 64'd90);
    checkOutput("m11_lat", 64'(lat), 64'd13);
    tick();
    runOp(8, 2'b00, 16'd77, 16'd0, y, lat, busyAll);
    checkOutput("m00_zero_y", y, 64'd0);
    checkOutput("m00_zero_lat", 64'(lat), 64'd9);

    $display("[TB] start during busy and during DONE");
    tick();
    applyStimulus(8, 2'b00, 16'd3, 16'd16);
    tick();
    dropStart(8);
    tick();
    tick();
    tick();
    applyStimulus(8, 2'b10, 16'd255, 16'd255);
    tick();
    dropStart(8);
    waitDone(8, lat, busyAll);
    checkOutput("ign_y", curY(8), 64'd12);
    checkOutput("ign_lat", 64'(lat + 4), 64'd9);
    checkOutput("ign_busy", {63'b0, busyAll}, 64'd1);
    applyStimulus(8, 2'b01, 16'd0, 16'd255);
    tick();
    dropStart(8);
    checkOutput("ign_done_busy", {63'b0, busy8}, 64'd0);
    checkOutput("ign_done_y", curY(8), 64'd12);
    tick();
    checkOutput("ign_idle_busy", {63'b0, busy8}, 64'd0);
    checkOutput("ign_idle_done", {63'b0, done8}, 64'd0);
    checkOutput("ign_idle_y", curY(8), 64'd12);

    $display("[TB] reset mid-MUL with start asserted");
    applyStimulus(8, 2'b10, 16'd200, 16'd100);
    tick();
    dropStart(8);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(8, 2'b00, 16'd5, 16'd5);
    tick();
    rst = 1'b0;
    dropStart(8);
    checkOutput("rst_busy", {63'b0, busy8}, 64'd0);
    checkOutput("rst_y", curY(8), 64'd0);
    checkOutput("rst_done", {63'b0, done8}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done8 || busy8) pulses++;
    end
    checkOutput("rst_no_done", 64'(pulses), 64'd0);
    runOp(8, 2'b10, 16'd13, 16'd11, y, lat, busyAll);
    checkOutput("rst_fresh_y", y, 64'd143);
    checkOutput("rst_fresh_lat", 64'(lat), 64'd9);

    $display("[TB] W=16 directed");
    tick();
    runOp(16, 2'b00, 16'd65535, 16'd65535, y, lat, busyAll);
    checkOutput("w16_m00_y", y, 64'd16711425);
    checkOutput("w16_m00_lat", 64'(lat), 64'd17);
    tick();
    runOp(16, 2'b11, 16'd10000, 16'd40000, y, lat, busyAll);
    checkOutput("w16_m11_y", y, 64'd20000);
    checkOutput("w16_m11_lat", 64'(lat), 64'd25);
    tick();
    runOp(16, 2'b10, 16'd1234, 16'd5678, y, lat, busyAll);
    checkOutput("w16_m10_y", y, 64'd7006652);
    checkOutput("w16_m10_lat", 64'(lat), 64'd17);
    tick();
    runOp(16, 2'b01, 16'd0, 16'd65535, y, lat, busyAll);
    checkOutput("w16_m01_y", y, 64'd255);
    checkOutput("w16_m01_lat", 64'(lat), 64'd9);

    $display("[TB] random sweep");
    for (int i = 0; i < 16; i++) begin
      int          dut;
      logic [1:0]  mode;
      logic [15:0] a;
      logic [15:0] b;
      dut  = (i < 8) ? 8 : 16;
      mode = 2'($urandom_range(0, 3));
      a    = 16'($urandom_range(0, (dut == 8) ? 255 : 65535));
      b    = 16'($urandom_range(0, (dut == 8) ? 255 : 65535));
      tick();
      runOp(dut, mode, a, b, y, lat, busyAll);
      checkOutput($sformatf("sweep%0d_w%0d_m%0d_y", i, dut, mode), y,
                  64'(refResult(mode, longint'(a), longint'(b))));
      checkOutput($sformatf("sweep%0d_w%0d_m%0d_lat", i, dut, mode), 64'(lat),
                  64'(refLatency(mode, dut)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
